// File: rtl/regfile_wb_ctrl_if.sv
// Bundle of the execute/LSU/decode-facing signals of the register-file write-back controller.
// The producer side (execute, LSU, decode) uses master; the controller uses slave.
interface regfile_wb_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
);
  logic                     enable_halt;

  logic                     alu_valid;
  logic                     alu_ready;
  logic [ADDR_W-1:0]        alu_dest;
  logic [DATA_W-1:0]        alu_data;

  logic                     lu_valid;
  logic                     lu_ready;
  logic [ADDR_W-1:0]        lu_dest;
  logic [DATA_W-1:0]        lu_data;

  logic                     iss_valid;
  logic [ADDR_W-1:0]        iss_dest;

  logic [ADDR_W-1:0]        rs1_addr;
  logic [ADDR_W-1:0]        rs2_addr;
  logic                     busy_rs1;
  logic                     busy_rs2;

  logic                     rg_wrt_en;
  logic [ADDR_W-1:0]        rg_wrt_dest;
  logic [DATA_W-1:0]        rg_wrt_data;

  logic [$clog2(DEPTH):0]   fifo_count;

  modport master (
    output enable_halt,
    output alu_valid, alu_dest, alu_data,
    input  alu_ready,
    output lu_valid, lu_dest, lu_data,
    input  lu_ready,
    output iss_valid, iss_dest,
    output rs1_addr, rs2_addr,
    input  busy_rs1, busy_rs2,
    input  rg_wrt_en, rg_wrt_dest, rg_wrt_data,
    input  fifo_count
  );

  modport slave (
    input  enable_halt,
    input  alu_valid, alu_dest, alu_data,
    output alu_ready,
    input  lu_valid, lu_dest, lu_data,
    output lu_ready,
    input  iss_valid, iss_dest,
    input  rs1_addr, rs2_addr,
    output busy_rs1, busy_rs2,
    output rg_wrt_en, rg_wrt_dest, rg_wrt_data,
    output fifo_count
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back controller: arbitrates ALU results against a FIFO of long-latency
// results for the single write port and tracks pending long-latency destinations for decode.
module regfile_wb_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  regfile_wb_ctrl_if.slave  wb
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_MAX + 1);
  localparam int NREG  = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ST_W-1:0]    starve_q, starve_d;
  logic [NREG-1:0]    pend_q, pend_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_dest_q, wr_dest_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;

  logic   active, empty, full, starve_hit;
  logic   push, pop, alu_fire;
  entry_t head;

  assign active     = !rst && !wb.enable_halt;
  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_W'(DEPTH));
  assign head       = mem_q[rd_ptr_q];
  assign starve_hit = !empty && (starve_q == ST_W'(STARVE_MAX));

  // The FIFO head owns the slot when the ALU is idle or has starved it long enough.
  assign pop      = active && !empty && (starve_hit || !wb.alu_valid);
  assign alu_fire = wb.alu_valid && wb.alu_ready;
  assign push     = wb.lu_valid && wb.lu_ready;

  assign wb.alu_ready   = active && !starve_hit;
  assign wb.lu_ready    = active && !full;
  assign wb.busy_rs1    = pend_q[wb.rs1_addr];
  assign wb.busy_rs2    = pend_q[wb.rs2_addr];
  assign wb.rg_wrt_en   = wr_en_q;
  assign wb.rg_wrt_dest = wr_dest_q;
  assign wb.rg_wrt_data = wr_data_q;
  assign wb.fifo_count  = count_q;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    starve_d  = starve_q;
    pend_d    = pend_q;
    wr_en_d   = 1'b0;
    wr_dest_d = wr_dest_q;
    wr_data_d = wr_data_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    if (active) begin
      if (pop || empty)  starve_d = '0;
      else if (alu_fire) starve_d = starve_q + 1'b1;

      if (pop) begin
        wr_en_d   = (head.dest != '0);
        wr_dest_d = head.dest;
        wr_data_d = head.data;
        pend_d[head.dest] = 1'b0;
      end else if (alu_fire) begin
        wr_en_d   = (wb.alu_dest != '0);
        wr_dest_d = wb.alu_dest;
        wr_data_d = wb.alu_data;
      end

      // Applied after the clear so a same-cycle issue to the popped register stays pending.
      if (wb.iss_valid && (wb.iss_dest != '0)) pend_d[wb.iss_dest] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only; reset here is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      pend_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_dest_q <= '0;
      wr_data_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      pend_q    <= pend_d;
      wr_en_q   <= wr_en_d;
      wr_dest_q <= wr_dest_d;
      wr_data_q <= wr_data_d;
    end
  end

  // NOTE: storage is left unreset; occupancy alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{dest: wb.lu_dest, data: wb.lu_data};
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed scenarios plus randomized traffic, all
// compared each cycle against a queue-based reference model of the write-back rules.
module tb_regfile_wb_ctrl;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) wb ();

  regfile_wb_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  typedef struct {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              m_q[$];
  bit                m_pend[2**ADDR_W];
  int                m_starve;
  logic              m_en;
  logic [ADDR_W-1:0] m_dest;
  logic [DATA_W-1:0] m_data;

  logic exp_alu_ready, exp_lu_ready;
  logic a_hold, l_hold, last_lu_acc;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_starve = 0;
    m_en     = 1'b0;
    m_dest   = '0;
    m_data   = '0;
  endtask

  // Compare every observable output against the model's current state.
  task automatic compare();
    exp_alu_ready = !rst && !wb.enable_halt && !(m_q.size() > 0 && m_starve == STARVE_MAX);
    exp_lu_ready  = !rst && !wb.enable_halt && (m_q.size() < DEPTH);
    check("alu_ready",  DATA_W'(wb.alu_ready),  DATA_W'(exp_alu_ready));
    check("lu_ready",   DATA_W'(wb.lu_ready),   DATA_W'(exp_lu_ready));
    check("busy_rs1",   DATA_W'(wb.busy_rs1),   DATA_W'(m_pend[wb.rs1_addr]));
    check("busy_rs2",   DATA_W'(wb.busy_rs2),   DATA_W'(m_pend[wb.rs2_addr]));
    check("fifo_count", DATA_W'(wb.fifo_count), DATA_W'(m_q.size()));
    check("wrt_en",     DATA_W'(wb.rg_wrt_en),  DATA_W'(m_en));
    if (m_en) begin
      check("wrt_dest", DATA_W'(wb.rg_wrt_dest), DATA_W'(m_dest));
      check("wrt_data", wb.rg_wrt_data, m_data);
    end
  endtask

  // Apply the current inputs to the model as the coming rising edge would.
  task automatic model_update();
    ent_t e;
    int   sz;
    sz          = m_q.size();
    last_lu_acc = 1'b0;
    a_hold      = wb.alu_valid && !exp_alu_ready;
    l_hold      = wb.lu_valid && !exp_lu_ready;
    if (rst) begin
      model_reset();
    end else if (wb.enable_halt) begin
      m_en = 1'b0;
    end else begin
      if (sz > 0 && (!wb.alu_valid || m_starve == STARVE_MAX)) begin
        e = m_q.pop_front();
        m_en   = (e.dest != 0);
        m_dest = e.dest;
        m_data = e.data;
        m_pend[e.dest] = 1'b0;
        m_starve = 0;
      end else if (wb.alu_valid) begin
        m_en   = (wb.alu_dest != 0);
        m_dest = wb.alu_dest;
        m_data = wb.alu_data;
        m_starve = (sz > 0) ? m_starve + 1 : 0;
      end else begin
        m_en = 1'b0;
        m_starve = 0;
      end
      if (wb.lu_valid && sz < DEPTH) begin
        m_q.push_back('{dest: wb.lu_dest, data: wb.lu_data});
        last_lu_acc = 1'b1;
      end
      if (wb.iss_valid && wb.iss_dest != 0) m_pend[wb.iss_dest] = 1'b1;
      m_pend[0] = 1'b0;
    end
  endtask

  // Inputs are set just after a falling edge; check, step the model, advance one cycle.
  task automatic tick();
    #1;
    compare();
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wb.enable_halt = 1'b0;
    wb.alu_valid = 1'b0; wb.alu_dest = '0; wb.alu_data = '0;
    wb.lu_valid  = 1'b0; wb.lu_dest  = '0; wb.lu_data  = '0;
    wb.iss_valid = 1'b0; wb.iss_dest = '0;
    wb.rs1_addr  = '0;   wb.rs2_addr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int pushed;
    int thr;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    a_hold = 1'b0; l_hold = 1'b0;
    @(negedge clk);

    // Reset state, then a single ALU write and its one-cycle pulse.
    do_reset();
    check("rst_dest", DATA_W'(wb.rg_wrt_dest), '0);
    check("rst_data", wb.rg_wrt_data, '0);
    wb.alu_valid = 1'b1; wb.alu_dest = 5'd5; wb.alu_data = 32'hDEADBEEF;
    tick();
    wb.alu_valid = 1'b0;
    check("t1_en",   DATA_W'(wb.rg_wrt_en), 1);
    check("t1_dest", DATA_W'(wb.rg_wrt_dest), 5);
    check("t1_data", wb.rg_wrt_data, 32'hDEADBEEF);
    tick();
    check("t1_en_off", DATA_W'(wb.rg_wrt_en), 0);

    // Issue to x7, result returns later; busy clears with the write.
    wb.iss_valid = 1'b1; wb.iss_dest = 5'd7; wb.rs1_addr = 5'd7;
    tick();
    wb.iss_valid = 1'b0;
    check("t2_busy_set", DATA_W'(wb.busy_rs1), 1);
    tick(); tick();
    wb.lu_valid = 1'b1; wb.lu_dest = 5'd7; wb.lu_data = 32'h1234;
    tick();
    wb.lu_valid = 1'b0;
    check("t2_busy_held", DATA_W'(wb.busy_rs1), 1);
    check("t2_no_wr_yet", DATA_W'(wb.rg_wrt_en), 0);
    tick();
    check("t2_en",   DATA_W'(wb.rg_wrt_en), 1);
    check("t2_dest", DATA_W'(wb.rg_wrt_dest), 7);
    check("t2_data", wb.rg_wrt_data, 32'h1234);
    check("t2_busy_clr", DATA_W'(wb.busy_rs1), 0);

    // Fill the FIFO under continuous ALU traffic; starvation guard must drain it in order.
    do_reset();
    pushed = 0;
    for (int c = 0; c < 24; c++) begin
      if (!a_hold) begin
        wb.alu_valid = 1'b1; wb.alu_dest = 5'($urandom_range(1, 31)); wb.alu_data = $urandom;
      end
      wb.lu_valid = (pushed < DEPTH);
      wb.lu_dest  = 5'(10 + pushed);
      wb.lu_data  = 32'h100 + 32'(pushed);
      tick();
      if (last_lu_acc) pushed++;
      if (c == 3) begin
        check("t3_count_full", DATA_W'(wb.fifo_count), DEPTH);
        check("t3_lu_ready",   DATA_W'(wb.lu_ready), 0);
        check("t3_alu_ready",  DATA_W'(wb.alu_ready), 0);
      end
    end
    wb.lu_valid = 1'b0;
    wb.alu_valid = 1'b0;
    tick();
    check("t3_drained", DATA_W'(wb.fifo_count), 0);

    // x0 from both sources: accepted, never written.
    wb.alu_valid = 1'b1; wb.alu_dest = '0; wb.alu_data = 32'hAAAA;
    wb.lu_valid  = 1'b1; wb.lu_dest  = '0; wb.lu_data  = 32'hBBBB;
    tick();
    wb.alu_valid = 1'b0; wb.lu_valid = 1'b0;
    check("t4_x0_alu", DATA_W'(wb.rg_wrt_en), 0);
    tick();
    check("t4_x0_lu", DATA_W'(wb.rg_wrt_en), 0);
    check("t4_count", DATA_W'(wb.fifo_count), 0);

    // Halt with two buffered results and a waiting ALU result.
    do_reset();
    wb.alu_valid = 1'b1; wb.alu_dest = 5'd4; wb.alu_data = 32'h44;
    for (int k = 0; k < 2; k++) begin
      wb.lu_valid = 1'b1; wb.lu_dest = 5'(20 + k); wb.lu_data = 32'h200 + 32'(k);
      tick();
    end
    wb.lu_valid = 1'b0;
    wb.enable_halt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t5_halt_count", DATA_W'(wb.fifo_count), 2);
      check("t5_halt_en",    DATA_W'(wb.rg_wrt_en), 0);
    end
    wb.enable_halt = 1'b0;
    wb.alu_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("t5_resume", DATA_W'(wb.fifo_count), 0);

    // Reset mid-operation drops buffered entries and pending bits.
    do_reset();
    wb.iss_valid = 1'b1; wb.iss_dest = 5'd3; tick();
    wb.iss_dest = 5'd9; tick();
    wb.iss_valid = 1'b0;
    wb.alu_valid = 1'b1; wb.alu_dest = 5'd1; wb.alu_data = 32'h11;
    for (int k = 0; k < 3; k++) begin
      wb.lu_valid = 1'b1; wb.lu_dest = 5'(3 + 6 * (k % 2)); wb.lu_data = 32'h300 + 32'(k);
      tick();
    end
    wb.lu_valid = 1'b0; wb.alu_valid = 1'b0;
    wb.rs1_addr = 5'd3; wb.rs2_addr = 5'd9;
    check("t6_pre_count", DATA_W'(wb.fifo_count), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_count", DATA_W'(wb.fifo_count), 0);
    check("t6_busy3", DATA_W'(wb.busy_rs1), 0);
    check("t6_busy9", DATA_W'(wb.busy_rs2), 0);
    check("t6_en",    DATA_W'(wb.rg_wrt_en), 0);

    // Randomized traffic with alternating ALU pressure; sources hold while not accepted.
    a_hold = 1'b0; l_hold = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      thr = ((c % 200) < 100) ? 9 : 3;
      rst = ($urandom_range(0, 299) == 0);
      wb.enable_halt = ($urandom_range(0, 11) == 0);
      if (!a_hold) begin
        wb.alu_valid = ($urandom_range(0, 9) < thr);
        wb.alu_dest  = 5'($urandom_range(0, 7));
        wb.alu_data  = $urandom;
      end
      if (!l_hold) begin
        wb.lu_valid = ($urandom_range(0, 9) < 4);
        wb.lu_dest  = 5'($urandom_range(0, 7));
        wb.lu_data  = $urandom;
      end
      wb.iss_valid = ($urandom_range(0, 3) == 0);
      wb.iss_dest  = 5'($urandom_range(0, 7));
      wb.rs1_addr  = 5'($urandom_range(0, 7));
      wb.rs2_addr  = 5'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
